// File: rtl/vga_pkg.sv
// Shared display-space constants and the movement-source encoding used by the
// block position logic.
package vga_pkg;

   localparam int H_VIS_START = 144;
   localparam int H_VIS_END   = 783;
   localparam int V_VIS_START = 35;
   localparam int V_VIS_END   = 514;
   localparam int BLOCK_SIZE  = 20;

   typedef enum logic [1:0] {
      SRC_IDLE = 2'd0,
      SRC_BTN  = 2'd1,
      SRC_ACC  = 2'd2
   } src_t;

   // Saturate a signed candidate coordinate into [lo, hi]; never wraps.
   function automatic logic [9:0] clamp_coord(input logic signed [10:0] cand,
                                              input logic [9:0] lo,
                                              input logic [9:0] hi);
      logic [9:0] res;
      res = cand[9:0];
      if (cand < signed'({1'b0, lo}))
         res = lo;
      else if (cand > signed'({1'b0, hi}))
         res = hi;
      return res;
   endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Board-side inputs and block-drawing outputs of the move scheduler, grouped
// so the scheduler and its driver share one bundle.
interface move_scheduler_if;

   logic       BtnU;
   logic       BtnD;
   logic       BtnL;
   logic       BtnR;
   logic [8:0] accel_x;
   logic       accel_en;
   logic [9:0] pos_x;
   logic [9:0] pos_y;
   logic [1:0] src;
   logic       moving;
   logic       tick;

   modport master (
      output BtnU, BtnD, BtnL, BtnR, accel_x, accel_en,
      input  pos_x, pos_y, src, moving, tick
   );

   modport slave (
      input  BtnU, BtnD, BtnL, BtnR, accel_x, accel_en,
      output pos_x, pos_y, src, moving, tick
   );

endinterface

// File: rtl/move_scheduler_btn_debounce.sv
// Two-flop synchronizer followed by a stability counter; the committed level
// only flips after the synchronized level has disagreed for DEB_CYCLES cycles.
module btn_debounce #(
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_level
);

   localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          level_q, level_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      cnt_d   = '0;
      level_d = level_q;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST)
            level_d = sync2_q;
         else
            cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign btn_level = level_q;

endmodule

// File: rtl/move_scheduler.sv
// Owns the block position: once per movement tick it picks buttons or tilt as
// the owner and applies a clamped step in display hCount/vCount space.
module move_scheduler
   import vga_pkg::*;
#(
   parameter int TICK_CYCLES = 1000000,
   parameter int DEB_CYCLES  = 500000,
   parameter int STEP        = 2,
   parameter int ACC_STEP    = 1,
   parameter int ACC_CENTER  = 256,
   parameter int ACC_DEAD    = 16,
   parameter int X_MIN       = H_VIS_START,
   parameter int X_MAX       = H_VIS_END - BLOCK_SIZE,
   parameter int Y_MIN       = V_VIS_START,
   parameter int Y_MAX       = V_VIS_END - BLOCK_SIZE,
   parameter int X_INIT      = 450,
   parameter int Y_INIT      = 250
) (
   input logic             ClkPort,
   input logic             Reset,
   move_scheduler_if.slave bus
);

   localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_CYCLES - 1);
   localparam logic [8:0]        ACC_HI    = 9'(ACC_CENTER + ACC_DEAD);
   localparam logic [8:0]        ACC_LO    = 9'(ACC_CENTER - ACC_DEAD);
   localparam logic signed [10:0] STEP_S   = 11'(STEP);
   localparam logic signed [10:0] ACC_S    = 11'(ACC_STEP);
   localparam logic [9:0]        X_LO      = 10'(X_MIN);
   localparam logic [9:0]        X_HI      = 10'(X_MAX);
   localparam logic [9:0]        Y_LO      = 10'(Y_MIN);
   localparam logic [9:0]        Y_HI      = 10'(Y_MAX);

   logic btn_u, btn_d, btn_l, btn_r;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_u (
      .clk(ClkPort), .rst(Reset), .btn_raw(bus.BtnU), .btn_level(btn_u));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (
      .clk(ClkPort), .rst(Reset), .btn_raw(bus.BtnD), .btn_level(btn_d));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
      .clk(ClkPort), .rst(Reset), .btn_raw(bus.BtnL), .btn_level(btn_l));
   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
      .clk(ClkPort), .rst(Reset), .btn_raw(bus.BtnR), .btn_level(btn_r));

   logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
   logic              tick_q, tick_d;
   src_t              src_q, src_d;
   logic [9:0]        pos_x_q, pos_x_d;
   logic [9:0]        pos_y_q, pos_y_d;
   logic              moving_q, moving_d;
   logic              btn_req, acc_hi, acc_lo, acc_req;
   logic signed [10:0] dx, dy;

   assign btn_req = btn_u | btn_d | btn_l | btn_r;
   assign acc_hi  = bus.accel_x > ACC_HI;
   assign acc_lo  = bus.accel_x < ACC_LO;
   assign acc_req = bus.accel_en & (acc_hi | acc_lo);

   // The move on a tick is chosen by the owner being entered, not the one left.
   always_comb begin
      tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
      tick_d     = (tick_cnt_d == TICK_LAST);
      src_d      = src_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      moving_d   = moving_q;
      dx         = '0;
      dy         = '0;
      if (tick_q) begin
         case (src_q)
            SRC_IDLE: src_d = btn_req ? SRC_BTN : (acc_req ? SRC_ACC : SRC_IDLE);
            SRC_BTN:  src_d = btn_req ? SRC_BTN : SRC_IDLE;
            SRC_ACC:  src_d = btn_req ? SRC_BTN : (acc_req ? SRC_ACC : SRC_IDLE);
            default:  src_d = SRC_IDLE;
         endcase
         case (src_d)
            SRC_BTN: begin
               dx = (btn_r ? STEP_S : 11'sd0) - (btn_l ? STEP_S : 11'sd0);
               dy = (btn_d ? STEP_S : 11'sd0) - (btn_u ? STEP_S : 11'sd0);
            end
            SRC_ACC: dx = acc_hi ? ACC_S : -ACC_S;
            default: ;
         endcase
         pos_x_d  = clamp_coord(signed'({1'b0, pos_x_q}) + dx, X_LO, X_HI);
         pos_y_d  = clamp_coord(signed'({1'b0, pos_y_q}) + dy, Y_LO, Y_HI);
         moving_d = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
      end
   end

   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
         src_q      <= SRC_IDLE;
         pos_x_q    <= 10'(X_INIT);
         pos_y_q    <= 10'(Y_INIT);
         moving_q   <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
         src_q      <= src_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         moving_q   <= moving_d;
      end
   end

   assign bus.pos_x  = pos_x_q;
   assign bus.pos_y  = pos_y_q;
   assign bus.src    = src_q;
   assign bus.moving = moving_q;
   assign bus.tick   = tick_q;

endmodule
